// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 codes, FSM state type and access-size helper shared by dmem_unit.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE,
        SECOND
    } state_t;

    // Byte count of an access; invalid codes fall into the word case and are rejected elsewhere.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store-side lane steering/byte enables and load-side gather/extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    input  logic [63:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [7:0]  o_be,
    output logic [31:0] o_rdata
);

    logic [4:0]  w_shift;
    logic [63:0] w_rot;
    logic [7:0]  w_mask;
    logic [31:0] w_gather;

    assign w_shift = {i_lane, 3'b000};

    // Rotation: bytes pushed past lane 3 wrap to the low lanes, which is exactly the word+1 half.
    assign w_rot   = {i_wdata, i_wdata} << w_shift;
    assign o_wdata = w_rot[63:32];

    assign w_mask = (size_of(i_funct3) == 3'd1) ? 8'h01 :
                    (size_of(i_funct3) == 3'd2) ? 8'h03 : 8'h0F;
    assign o_be   = w_mask << i_lane;

    assign w_gather = 32'(i_rdata >> w_shift);

    always_comb begin
        o_rdata = 32'd0;
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_gather[7]}}, w_gather[7:0]};
            F3_H:    o_rdata = {{16{w_gather[15]}}, w_gather[15:0]};
            F3_W:    o_rdata = w_gather;
            F3_BU:   o_rdata = {24'd0, w_gather[7:0]};
            F3_HU:   o_rdata = {16'd0, w_gather[15:0]};
            default: o_rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_unit.sv
// dmem_unit: byte-addressed RV32 data memory with handshake and registered response.
// Define DMEM_MISALIGN_EN to split word-crossing accesses over two cycles; otherwise they fault.
//   state  | meaning
//   IDLE   | ready; non-crossing accesses and errors respond next cycle
//   SECOND | busy; upper lanes of a crossing access at word+1
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_stall
);

    localparam int WORD_W = ADDR_W - 2;
    localparam int DEPTH  = 1 << WORD_W;

    logic [3:0][7:0] r_mem [DEPTH];
    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic [31:0]     r_rsp_rdata;

    logic              w_accept, w_bad_f3, w_bad_st, w_bad_range, w_cross, w_err, w_wr_en;
    logic [32:0]       w_end;
    logic [WORD_W-1:0] w_word, w_idx;
    logic [1:0]        w_al_lane;
    logic [2:0]        w_al_f3;
    logic [31:0]       w_st_data, w_ld_data, w_rd_word, w_wr_data;
    logic [63:0]       w_raw;
    logic [7:0]        w_be;
    logic [3:0]        w_wr_be;

    assign w_accept    = i_req_valid & o_req_ready;
    assign w_word      = i_req_addr[ADDR_W-1:2];
    assign w_bad_f3    = (i_req_funct3 == 3'b011) || (i_req_funct3[2:1] == 2'b11);
    assign w_bad_st    = i_req_we && ((i_req_funct3 == F3_BU) || (i_req_funct3 == F3_HU));
    assign w_end       = {1'b0, i_req_addr} + {30'd0, size_of(i_req_funct3)} - 33'd1;
    assign w_bad_range = (w_end >> ADDR_W) != 33'd0;
    assign w_cross     = |w_be[7:4];
    assign w_rd_word   = r_mem[w_idx];

`ifdef DMEM_MISALIGN_EN
    state_t            r_state;
    logic              r_ready, r_we;
    logic [1:0]        r_lane;
    logic [2:0]        r_f3;
    logic [WORD_W-1:0] r_word;
    logic [31:0]       r_wdata, r_lo;
    logic [3:0]        r_be_hi;
    logic              w_second;

    assign o_req_ready = r_ready;
    assign w_second    = (r_state == SECOND);
    assign w_err       = w_bad_f3 | w_bad_st | w_bad_range;
    assign w_al_lane   = w_second ? r_lane : i_req_addr[1:0];
    assign w_al_f3     = w_second ? r_f3 : i_req_funct3;
    assign w_idx       = w_second ? r_word + WORD_W'(1) : w_word;
    assign w_raw       = w_second ? {w_rd_word, r_lo} : {32'd0, w_rd_word};
    assign w_wr_en     = w_second ? r_we : (w_accept & i_req_we & ~w_err);
    assign w_wr_be     = w_second ? r_be_hi : w_be[3:0];
    assign w_wr_data   = w_second ? r_wdata : w_st_data;
`else
    assign o_req_ready = 1'b1;
    assign w_err       = w_bad_f3 | w_bad_st | w_bad_range | w_cross;
    assign w_al_lane   = i_req_addr[1:0];
    assign w_al_f3     = i_req_funct3;
    assign w_idx       = w_word;
    assign w_raw       = {32'd0, w_rd_word};
    assign w_wr_en     = w_accept & i_req_we & ~w_err;
    assign w_wr_be     = w_be[3:0];
    assign w_wr_data   = w_st_data;
`endif

    dmem_lane_align u_align (
        .i_lane   (w_al_lane),
        .i_funct3 (w_al_f3),
        .i_wdata  (i_req_wdata),
        .i_rdata  (w_raw),
        .o_wdata  (w_st_data),
        .o_be     (w_be),
        .o_rdata  (w_ld_data)
    );

    // Gated by reset so a reset coinciding with an accept or with SECOND writes nothing.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wr_be[b]) r_mem[w_idx][b] <= w_wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
`ifdef DMEM_MISALIGN_EN
            r_state <= IDLE;
            r_ready <= 1'b1;
`endif
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
`ifdef DMEM_MISALIGN_EN
            if (w_second) begin
                r_state     <= IDLE;
                r_ready     <= 1'b1;
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= r_we ? 32'd0 : w_ld_data;
            end else
`endif
            if (w_accept) begin
                if (w_err) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b1;
                    r_rsp_rdata <= 32'd0;
                end
`ifdef DMEM_MISALIGN_EN
                else if (w_cross) begin
                    r_state <= SECOND;
                    r_ready <= 1'b0;
                    r_we    <= i_req_we;
                    r_lane  <= i_req_addr[1:0];
                    r_f3    <= i_req_funct3;
                    r_word  <= w_word;
                    r_lo    <= w_rd_word;
                    r_wdata <= w_st_data;
                    r_be_hi <= w_be[7:4];
                end
`endif
                else begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= i_req_we ? 32'd0 : w_ld_data;
                end
            end
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_stall     = ~o_req_ready;

endmodule

// File: doc/dmem_unit.md
# dmem_unit

Byte-addressed RV32 data memory for the MEM stage, built as a parametrised successor to the single-cycle data store. It adds request/response handshaking and a registered read path, and implements memory as 4 byte lanes of 2^ADDR_W/4 words. It detects error conditions, and can split word-crossing (misaligned) accesses into two cycles. It sits between the EX/MEM pipeline register and the writeback mux, and raises a stall to the hazard unit while busy.

## Interface
- ADDR_W, 10, byte-address width; capacity = 2^ADDR_W bytes (ADDR_W ≥ 2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; handshake = req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  one-cycle pulse, response/completion
- rsp_rdata  out  32  load result, extended per funct3; 0 for stores and errors
- rsp_err  out  1  valid with rsp_valid; access faulted
- stall  out  1  = ~req_ready

## Operation
- Size: B = 1, H = 2, W = 4 bytes. Lane = addr[1:0]. Word index = addr[ADDR_W-1:2].
- Errors are checked at accept. On any error: no write occurs, rsp_err = 1, rsp_rdata = 0. The error conditions are:
  - funct3 in {011, 110, 111};
  - store with funct3 100/101;
  - addr + size − 1 ≥ 2^ADDR_W, i.e. no wrap-around.
- Non-crossing access (lane + size ≤ 4) completes in one cycle.
  - Store: the byte enables for the covered lanes are written at the accept edge.
  - Load: the lanes are read at the accept edge, shifted down and extended (signed for B/H, zero for BU/HU).
- Crossing access (lane + size > 4): see Configuration.
- FSM states:
  - IDLE: req_ready = 1. A crossing accept goes to SECOND; all other accepts stay in IDLE.
  - SECOND: req_ready = 0. Handles the upper lanes at word+1, then returns to IDLE.
- rsp_valid pulses once per accepted request. There is no response backpressure; the consumer must take it.
- A store followed by a load to the same address on the next accept returns the new data.
- Memory contents are not reset and are not initialised in synthesis.

## Timing
- Reset values: req_ready = 1, stall = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, FSM = IDLE.
- Non-crossing access or error: accept at edge N → rsp_valid high for the cycle after N. Back-to-back accepts every cycle are allowed.
- Crossing access:
  - Accept at edge N: low lanes are written or read.
  - Edge N+1: high lanes are handled and the response is registered.
  - rsp_valid is high the cycle after N+1, and req_ready is low for the cycle between N and N+1.
  - Throughput is one crossing access per 2 cycles.
- rst asserted in SECOND: return to IDLE with no response. Bytes already written at edge N remain written.
- rst on the same edge as an accept: reset wins, with no write and no response.

## Configuration
- DMEM_MISALIGN_EN defined: crossing accesses use the two-cycle SECOND sequence.
- DMEM_MISALIGN_EN undefined: crossing accesses are errors.
  - rsp_err = 1 after one cycle, with no write.
  - The SECOND state and its logic are removed, and req_ready is tied to 1.

## Structure
- Package dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - FSM state enum (IDLE, SECOND);
  - function size_of(funct3).
- One sub-module, dmem_lane_align. It is combinational and does two jobs:
  - store path: lane steering plus byte-enable generation;
  - load path: byte gather plus sign/zero extension.
- The top holds the FSM, lane arrays, second-half address/data capture and response registers.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → 0xDEADBEEF. Then LB @0x13 → 0xFFFFFFDE, LBU @0x13 → 0x000000DE, LH @0x12 → 0xFFFFDEAD.
- SH 0x1234 @0x21, then LHU @0x21 → 0x00001234, one-cycle latency, no stall.
- With DMEM_MISALIGN_EN: SW 0xA1B2C3D4 @0x0E → stall for 1 cycle, rsp_valid 2 cycles after accept. Then LW @0x0E → 0xA1B2C3D4, and LBU @0x10 → 0xB2.
- Without DMEM_MISALIGN_EN: same SW @0x0E → rsp_err = 1 after 1 cycle, and a LW @0x0C afterwards shows the bytes unchanged.
- Bad requests each give rsp_err = 1 with no write:
  - LW @0x3FE with ADDR_W = 10 (out of range);
  - funct3 = 011;
  - store with funct3 = 101.
- Crossing store accepted with DMEM_MISALIGN_EN, then rst pulsed in SECOND → no rsp_valid, req_ready = 1 the next cycle. A subsequent LW @0x0C shows only the low-half bytes changed, @0x10 unchanged.
